lsq_mem_scheduler: RTL and testbench

LSQ_MEM_SCHEDULER -- requirements
Module: lsq_mem_scheduler

---
 rtl/lsq_mem_scheduler_pkg.sv | 31 +++
 rtl/lsq_mem_scheduler_if.sv | 21 ++
 rtl/lsq_mem_scheduler_age_picker.sv | 26 ++
 rtl/lsq_mem_scheduler.sv | 134 +++++++++++++
 tb/tb_lsq_mem_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_mem_scheduler_pkg.sv
// Shared definitions for the LSQ memory scheduler: queue depth, index types,
// FSM state encoding and the age-order slot helper.
`ifndef LSQ_SIZE
`define LSQ_SIZE 8
`endif

package lsq_mem_scheduler_pkg;

    localparam int unsigned LSQ_SIZE = `LSQ_SIZE;
    localparam int unsigned IDX_W    = $clog2(LSQ_SIZE + 1);
    localparam int unsigned SLOT_W   = (LSQ_SIZE > 1) ? $clog2(LSQ_SIZE) : 1;

    typedef logic [IDX_W-1:0]    idx_t;   // 1-based entry index
    typedef logic [SLOT_W-1:0]   slot_t;  // 0-based bit position
    typedef logic [LSQ_SIZE-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } sched_state_t;

    // Bit position of the entry k places younger than head, wrapping LSQ_SIZE -> 1.
    function automatic slot_t age_slot(input idx_t head, input int unsigned k);
        int unsigned h;
        h = 32'(head);
        if (h != 0) h = h - 1;
        return slot_t'((h + k) % LSQ_SIZE);
    endfunction

endpackage

// File: rtl/lsq_mem_scheduler_if.sv
// Memory-side request/grant/response bundle between the scheduler (master)
// and the memory port (slave).
interface lsq_mem_scheduler_if;

    logic                        mem_req;
    lsq_mem_scheduler_pkg::idx_t mem_index;
    logic                        mem_is_store;
    logic                        mem_gnt;
    logic                        mem_rsp_valid;

    modport master (
        output mem_req, mem_index, mem_is_store,
        input  mem_gnt, mem_rsp_valid
    );

    modport slave (
        input  mem_req, mem_index, mem_is_store,
        output mem_gnt, mem_rsp_valid
    );

endinterface

// File: rtl/lsq_mem_scheduler_age_picker.sv
// Combinational age-order picker: first set bit of the eligible vector,
// scanning from head and wrapping, reported as a 1-based index.
module lsq_age_picker
    import lsq_mem_scheduler_pkg::*;
(
    input  vec_t i_eligible,
    input  idx_t i_head,
    output logic o_found,
    output idx_t o_index
);

    always_comb begin : pick
        slot_t w_s;
        o_found = 1'b0;
        o_index = idx_t'(1);
        w_s     = '0;
        for (int unsigned k = 0; k < LSQ_SIZE; k++) begin
            w_s = age_slot(i_head, k);
            if (!o_found && i_eligible[w_s]) begin
                o_found = 1'b1;
                o_index = idx_t'(w_s) + idx_t'(1);
            end
        end
    end

endmodule

// File: rtl/lsq_mem_scheduler.sv
// LSQ memory scheduler: issues the oldest eligible entry, one access at a time.
// Build option LSQ_SPEC_LOAD_EN lets loads pass older stores with unknown address.
module lsq_mem_scheduler
    import lsq_mem_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  idx_t                       lsq_head,
    input  vec_t                       entry_valid,
    input  vec_t                       entry_addr_rdy,
    input  vec_t                       entry_is_store,
    input  logic                       store_commit,
    input  logic                       retire_valid,
    input  idx_t                       retire_index,
    input  logic                       flush,
    lsq_mem_scheduler_if.master        mem,
    output logic                       done_valid,
    output idx_t                       done_index,
    output logic                       busy
);

    sched_state_t r_state, w_state_nxt;
    vec_t         r_issued, w_issued_nxt, w_eligible;
    logic         w_found, w_pick_store;
    idx_t         w_pick_idx;
    idx_t         r_mem_index, r_done_index;
    logic         r_mem_is_store, r_done_valid;

    always_comb begin : elig
        slot_t w_s;
`ifndef LSQ_SPEC_LOAD_EN
        logic  w_blocked;
        w_blocked = 1'b0;
`endif
        w_eligible = '0;
        w_s        = '0;
        for (int unsigned k = 0; k < LSQ_SIZE; k++) begin
            w_s = age_slot(lsq_head, k);
            if (entry_valid[w_s] && entry_addr_rdy[w_s] && !r_issued[w_s]) begin
                if (entry_is_store[w_s])
                    w_eligible[w_s] = (k == 0) && store_commit;
`ifdef LSQ_SPEC_LOAD_EN
                else
                    w_eligible[w_s] = 1'b1;
`else
                else
                    w_eligible[w_s] = !w_blocked;
`endif
            end
`ifndef LSQ_SPEC_LOAD_EN
            // Younger loads stall behind any store whose address is still unknown.
            if (entry_valid[w_s] && entry_is_store[w_s] && !entry_addr_rdy[w_s])
                w_blocked = 1'b1;
`endif
        end
    end

    lsq_age_picker u_picker (
        .i_eligible (w_eligible),
        .i_head     (lsq_head),
        .o_found    (w_found),
        .o_index    (w_pick_idx)
    );

    always_comb begin
        w_pick_store = 1'b0;
        for (int unsigned i = 0; i < LSQ_SIZE; i++)
            if (w_pick_idx == idx_t'(i + 1)) w_pick_store = entry_is_store[slot_t'(i)];
    end

    // Retire is applied after the grant so it wins on a same-index collision.
    always_comb begin
        w_issued_nxt = r_issued;
        for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
            if (r_state == REQ && mem.mem_gnt && r_mem_index == idx_t'(i + 1))
                w_issued_nxt[slot_t'(i)] = 1'b1;
            if (retire_valid && retire_index == idx_t'(i + 1))
                w_issued_nxt[slot_t'(i)] = 1'b0;
        end
        if (flush) w_issued_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_found)           w_state_nxt = REQ;
                REQ:      if (mem.mem_gnt)       w_state_nxt = WAIT_RSP;
                WAIT_RSP: if (mem.mem_rsp_valid) w_state_nxt = IDLE;
                default:                         w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mem.mem_req      = (r_state == REQ);
        mem.mem_index    = r_mem_index;
        mem.mem_is_store = r_mem_is_store;
        busy             = (r_state != IDLE);
        done_valid       = r_done_valid;
        done_index       = r_done_index;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issued       <= '0;
            r_mem_index    <= idx_t'(1);
            r_mem_is_store <= 1'b0;
            r_done_valid   <= 1'b0;
            r_done_index   <= idx_t'(1);
        end else begin
            r_issued     <= w_issued_nxt;
            r_done_valid <= 1'b0;
            if (!flush) begin
                if (r_state == IDLE && w_found) begin
                    r_mem_index    <= w_pick_idx;
                    r_mem_is_store <= w_pick_store;
                end
                if (r_state == WAIT_RSP && mem.mem_rsp_valid) begin
                    r_done_valid <= 1'b1;
                    r_done_index <= r_mem_index;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
// Directed self-checking bench for lsq_mem_scheduler (LSQ_SIZE = 8).
module tb_lsq_mem_scheduler;
    import lsq_mem_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    idx_t lsq_head = idx_t'(1);
    vec_t entry_valid = '0, entry_addr_rdy = '0, entry_is_store = '0;
    logic store_commit = 1'b0, retire_valid = 1'b0, flush = 1'b0;
    idx_t retire_index = idx_t'(1);
    logic done_valid, busy;
    idx_t done_index;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    lsq_mem_scheduler_if mem ();

    lsq_mem_scheduler dut (
        .clk            (clk),
        .reset          (rst_n),
        .lsq_head       (lsq_head),
        .entry_valid    (entry_valid),
        .entry_addr_rdy (entry_addr_rdy),
        .entry_is_store (entry_is_store),
        .store_commit   (store_commit),
        .retire_valid   (retire_valid),
        .retire_index   (retire_index),
        .flush          (flush),
        .mem            (mem),
        .done_valid     (done_valid),
        .done_index     (done_index),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        entry_valid    = '0;
        entry_addr_rdy = '0;
        entry_is_store = '0;
        store_commit   = 1'b0;
        flush          = 1'b1;
        tick();
        flush          = 1'b0;
        lsq_head       = idx_t'(1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},    32'(mem.mem_req),      0);
        check({tag, "_idx"},    32'(mem.mem_index),    1);
        check({tag, "_st"},     32'(mem.mem_is_store), 0);
        check({tag, "_dv"},     32'(done_valid),       0);
        check({tag, "_di"},     32'(done_index),       1);
        check({tag, "_busy"},   32'(busy),             0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem.mem_gnt       = 1'b0;
        mem.mem_rsp_valid = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Empty queue: address-ready bits alone never start an access.
        entry_addr_rdy = 8'hFF;
        tick();
        tick();
        check("empty_req",  32'(mem.mem_req), 0);
        check("empty_busy", 32'(busy), 0);
        entry_addr_rdy = '0;

        // Single load at 3, immediate grant, response two cycles after grant.
        entry_valid = 8'h04; entry_addr_rdy = 8'h04;
        tick();
        check("ld3_req",  32'(mem.mem_req), 1);
        check("ld3_idx",  32'(mem.mem_index), 3);
        check("ld3_st",   32'(mem.mem_is_store), 0);
        mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        check("ld3_wait_req",  32'(mem.mem_req), 0);
        check("ld3_wait_busy", 32'(busy), 1);
        tick();
        check("ld3_wait_dv", 32'(done_valid), 0);
        mem.mem_rsp_valid = 1'b1;
        tick();
        mem.mem_rsp_valid = 1'b0;
        check("ld3_dv",   32'(done_valid), 1);
        check("ld3_di",   32'(done_index), 3);
        check("ld3_idle", 32'(busy), 0);
        tick();
        check("ld3_pulse", 32'(done_valid), 0);
        check("ld3_noreissue", 32'(mem.mem_req), 0);
        clear_q();

        // Wrap order: head 7, loads at 2 and 8 -> 8 first, then 2 picked in the done cycle.
        lsq_head = idx_t'(7); entry_valid = 8'h82; entry_addr_rdy = 8'h82;
        tick();
        check("wrap_idx8", 32'(mem.mem_index), 8);
        check("wrap_req8", 32'(mem.mem_req), 1);
        mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        mem.mem_rsp_valid = 1'b1;
        tick();
        mem.mem_rsp_valid = 1'b0;
        check("wrap_dv8",  32'(done_valid), 1);
        check("wrap_di8",  32'(done_index), 8);
        tick();
        check("wrap_req2", 32'(mem.mem_req), 1);
        check("wrap_idx2", 32'(mem.mem_index), 2);
        check("wrap_dv_off", 32'(done_valid), 0);
        mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        mem.mem_rsp_valid = 1'b1;
        tick();
        mem.mem_rsp_valid = 1'b0;
        check("wrap_di2", 32'(done_index), 2);
        clear_q();

        // Retire on the grant cycle wins: entry 6 becomes selectable again.
        entry_valid = 8'h20; entry_addr_rdy = 8'h20;
        tick();
        check("ret_idx", 32'(mem.mem_index), 6);
        mem.mem_gnt = 1'b1; retire_valid = 1'b1; retire_index = idx_t'(6);
        tick();
        mem.mem_gnt = 1'b0; retire_valid = 1'b0;
        mem.mem_rsp_valid = 1'b1;
        tick();
        mem.mem_rsp_valid = 1'b0;
        check("ret_di", 32'(done_index), 6);
        tick();
        check("ret_reissue_req", 32'(mem.mem_req), 1);
        check("ret_reissue_idx", 32'(mem.mem_index), 6);
        clear_q();

        // Flush in WAIT_RSP with a same-cycle response: dropped, issued cleared.
        entry_valid = 8'h10; entry_addr_rdy = 8'h10;
        tick();
        check("fl_idx", 32'(mem.mem_index), 5);
        mem.mem_gnt = 1'b1;
        tick();
        mem.mem_gnt = 1'b0;
        flush = 1'b1; mem.mem_rsp_valid = 1'b1;
        tick();
        flush = 1'b0; mem.mem_rsp_valid = 1'b0;
        check("fl_dv",   32'(done_valid), 0);
        check("fl_busy", 32'(busy), 0);
        check("fl_req",  32'(mem.mem_req), 0);
        tick();
        check("fl_dv2",      32'(done_valid), 0);
        check("fl_reissue",  32'(mem.mem_req), 1);
        check("fl_reidx",    32'(mem.mem_index), 5);
        clear_q();

        // Store at head 4 waits for commit; then grant withheld; then async reset.
        lsq_head = idx_t'(4);
        entry_valid = 8'h08; entry_addr_rdy = 8'h08; entry_is_store = 8'h08;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("st_nocommit", 32'(mem.mem_req), 0);
        end
        store_commit = 1'b1;
        tick();
        check("st_req", 32'(mem.mem_req), 1);
        check("st_idx", 32'(mem.mem_index), 4);
        check("st_st",  32'(mem.mem_is_store), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("st_hold_req", 32'(mem.mem_req), 1);
            check("st_hold_idx", 32'(mem.mem_index), 4);
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        store_commit = 1'b0;
        entry_valid = '0; entry_addr_rdy = '0; entry_is_store = '0;
        lsq_head = idx_t'(1);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_nodone", 32'(done_valid), 0);

        // Load at 3 behind store at 2 with unknown address.
        entry_valid = 8'h06; entry_addr_rdy = 8'h04; entry_is_store = 8'h02;
        tick();
`ifdef LSQ_SPEC_LOAD_EN
        check("spec_req", 32'(mem.mem_req), 1);
        check("spec_idx", 32'(mem.mem_index), 3);
`else
        for (int i = 0; i < 3; i++) begin
            check("cons_noissue", 32'(mem.mem_req), 0);
            tick();
        end
`endif
        clear_q();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
